// File: rtl/solver_sequencer.sv
// Phase sequencer for one ODE solve run: alternates Euler and Step phases,
// hands over to the interpolator, and aborts on INT, watchdog or iteration overflow.
module solver_sequencer #(
  parameter int ITER_WIDTH     = 16,
  parameter int MAX_ITER       = 1000,
  parameter int TIMEOUT_WIDTH  = 13,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  Process,
  input  logic                  INT,
  input  logic                  Euler_End,
  input  logic                  Step_End,
  input  logic                  Step_Last,
  input  logic                  Change_State_End,
  output logic                  Euler_Enable,
  output logic                  Step_Enable,
  output logic                  Change_State,
  output logic                  Done_Processing,
  output logic                  Busy,
  output logic                  Abort_Flag,
  output logic                  Timeout_Flag,
  output logic                  Overflow_Flag,
  output logic [ITER_WIDTH-1:0] Iter_Count,
  output logic [2:0]            Dbg_State
);

  // Handshake: each *_Enable is a level "run" request; the matching *_End is
  // sampled on the clock edge while the phase is active and is ignored otherwise.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_EULER  = 3'd1,
    S_STEP   = 3'd2,
    S_INTERP = 3'd3,
    S_DONE   = 3'd4,
    S_ABORT  = 3'd5
  } state_t;

  localparam logic [ITER_WIDTH-1:0]    LP_MAX_ITER = ITER_WIDTH'(MAX_ITER);
  localparam logic [TIMEOUT_WIDTH-1:0] LP_WD_LAST  = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

  state_t                  r_state;
  logic [TIMEOUT_WIDTH-1:0] r_wd;
  logic [ITER_WIDTH-1:0]   r_iter;
  logic                    r_abort;
  logic                    r_timeout;
  logic                    r_overflow;
  logic                    r_euler_en;
  logic                    r_step_en;
  logic                    r_interp_en;
  logic                    r_done;
  logic                    r_busy;

  state_t                  w_next_state;
  logic                    w_start;
  logic                    w_iter_inc;
  logic                    w_set_abort;
  logic                    w_set_timeout;
  logic                    w_set_overflow;
  logic                    w_wd_expired;
  logic                    w_run_state;
  logic [ITER_WIDTH-1:0]   w_iter_plus;

  always_comb begin
    w_next_state   = r_state;
    w_start        = 1'b0;
    w_iter_inc     = 1'b0;
    w_set_abort    = 1'b0;
    w_set_timeout  = 1'b0;
    w_set_overflow = 1'b0;
    w_wd_expired   = (r_wd == LP_WD_LAST);
    w_run_state    = (r_state == S_EULER) || (r_state == S_STEP) || (r_state == S_INTERP);
    w_iter_plus    = (r_iter == {ITER_WIDTH{1'b1}}) ? r_iter : r_iter + 1'b1;

    // Inside the run states the priority is INT, then the phase End, then watchdog.
    case (r_state)
      S_IDLE: begin
        if (Process) begin
          w_next_state = S_EULER;
          w_start      = 1'b1;
        end
      end
      S_EULER: begin
        if (INT) begin
          w_next_state = S_ABORT;
          w_set_abort  = 1'b1;
        end else if (Euler_End) begin
          w_next_state = S_STEP;
        end else if (w_wd_expired) begin
          w_next_state  = S_ABORT;
          w_set_abort   = 1'b1;
          w_set_timeout = 1'b1;
        end
      end
      S_STEP: begin
        if (INT) begin
          w_next_state = S_ABORT;
          w_set_abort  = 1'b1;
        end else if (Step_End) begin
          if (Step_Last) begin
            w_next_state = S_INTERP;
          end else begin
            w_iter_inc = 1'b1;
            if (w_iter_plus == LP_MAX_ITER) begin
              w_next_state   = S_ABORT;
              w_set_abort    = 1'b1;
              w_set_overflow = 1'b1;
            end else begin
              w_next_state = S_EULER;
            end
          end
        end else if (w_wd_expired) begin
          w_next_state  = S_ABORT;
          w_set_abort   = 1'b1;
          w_set_timeout = 1'b1;
        end
      end
      S_INTERP: begin
        if (INT) begin
          w_next_state = S_ABORT;
          w_set_abort  = 1'b1;
        end else if (Change_State_End) begin
          w_next_state = S_DONE;
        end else if (w_wd_expired) begin
          w_next_state  = S_ABORT;
          w_set_abort   = 1'b1;
          w_set_timeout = 1'b1;
        end
      end
      S_DONE:  w_next_state = S_IDLE;
      S_ABORT: w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Watchdog restarts on every state change, so each phase gets its own budget.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_wd <= '0;
    end else if (w_next_state != r_state) begin
      r_wd <= '0;
    end else if (w_run_state && !w_wd_expired) begin
      r_wd <= r_wd + 1'b1;
    end else if (!w_run_state) begin
      r_wd <= '0;
    end
  end

  // Iteration count and flags survive an abort so I/O can read them afterwards.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_iter     <= '0;
      r_abort    <= 1'b0;
      r_timeout  <= 1'b0;
      r_overflow <= 1'b0;
    end else if (w_start) begin
      r_iter     <= '0;
      r_abort    <= 1'b0;
      r_timeout  <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_iter_inc) begin
        r_iter <= w_iter_plus;
      end
      r_abort    <= r_abort    | w_set_abort;
      r_timeout  <= r_timeout  | w_set_timeout;
      r_overflow <= r_overflow | w_set_overflow;
    end
  end

  // Outputs decode the next state so they line up with the state register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_euler_en  <= 1'b0;
      r_step_en   <= 1'b0;
      r_interp_en <= 1'b0;
      r_done      <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_euler_en  <= (w_next_state == S_EULER);
      r_step_en   <= (w_next_state == S_STEP);
      r_interp_en <= (w_next_state == S_INTERP);
      r_done      <= (w_next_state == S_DONE);
      r_busy      <= (w_next_state != S_IDLE);
    end
  end

  assign Euler_Enable    = r_euler_en;
  assign Step_Enable     = r_step_en;
  assign Change_State    = r_interp_en;
  assign Done_Processing = r_done;
  assign Busy            = r_busy;
  assign Abort_Flag      = r_abort;
  assign Timeout_Flag    = r_timeout;
  assign Overflow_Flag   = r_overflow;
  assign Iter_Count      = r_iter;
  assign Dbg_State       = r_state;

endmodule

// File: tb/tb_solver_sequencer.sv
// Randomized scoreboard bench for solver_sequencer: a phase-level model predicts
// each phase's enable length and the end-of-run status; a monitor checks them.
module tb_solver_sequencer;
  localparam int MAX_ITER = 4;
  localparam int TO_CYC   = 8;
  localparam int W        = 20;

  logic        CLK;
  logic        RST;
  logic        Process, INT, Euler_End, Step_End, Step_Last, Change_State_End;
  logic        Euler_Enable, Step_Enable, Change_State, Done_Processing, Busy;
  logic        Abort_Flag, Timeout_Flag, Overflow_Flag;
  logic [15:0] Iter_Count;
  logic [2:0]  Dbg_State;

  solver_sequencer #(
    .ITER_WIDTH(16), .MAX_ITER(MAX_ITER), .TIMEOUT_WIDTH(13), .TIMEOUT_CYCLES(TO_CYC)
  ) dut (
    .CLK(CLK), .RST(RST), .Process(Process), .INT(INT),
    .Euler_End(Euler_End), .Step_End(Step_End), .Step_Last(Step_Last),
    .Change_State_End(Change_State_End),
    .Euler_Enable(Euler_Enable), .Step_Enable(Step_Enable), .Change_State(Change_State),
    .Done_Processing(Done_Processing), .Busy(Busy),
    .Abort_Flag(Abort_Flag), .Timeout_Flag(Timeout_Flag), .Overflow_Flag(Overflow_Flag),
    .Iter_Count(Iter_Count), .Dbg_State(Dbg_State)
  );

  // ---------------- clock / reset ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, required finish within time limit");
    $fatal(1, "global timeout");
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b1;

  // scenario description
  int lat[0:15];
  int last_step;
  int hang_ph;
  int int_ph;
  int int_c;
  bit rst_mode;

  function automatic logic [W-1:0] ph_tok(int t, int len);
    return {4'(t), 3'b000, 13'(len)};
  endfunction

  function automatic logic [W-1:0] res_tok(int done, bit ab, bit to, bit ov, int tail, int iter);
    return {4'hA, 2'(done), ab, to, ov, 2'(tail), 1'b0, 8'(iter)};
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic sb_check(string name, logic [W-1:0] act);
    logic [W-1:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: got %05h, expected nothing (queue empty)", name, act);
    end else begin
      e = exp_q.pop_front();
      if (act !== e) begin
        errors++;
        $display("FAIL %s: got %05h, expected %05h", name, act, e);
      end
    end
  endtask

  // Phase-level reference: walk E,S,E,S... (then I) and decide each phase's fate.
  task automatic model_push();
    int  iter;
    int  p;
    int  t;
    bit  fin;
    iter = 0;
    p    = 0;
    fin  = 1'b0;
    while (!fin && p < 16) begin
      if (p == 2 * last_step + 2) t = 3;
      else if (p % 2 == 0)        t = 1;
      else                        t = 2;
      if (p == int_ph) begin
        exp_q.push_back(ph_tok(t, int_c));
        exp_q.push_back(res_tok(0, 1, 0, 0, 1, iter));
        fin = 1'b1;
      end else if (p == hang_ph) begin
        exp_q.push_back(ph_tok(t, TO_CYC));
        exp_q.push_back(res_tok(0, 1, 1, 0, 1, iter));
        fin = 1'b1;
      end else begin
        exp_q.push_back(ph_tok(t, lat[p]));
        if (t == 3) begin
          exp_q.push_back(res_tok(1, 0, 0, 0, 1, iter));
          fin = 1'b1;
        end else if (t == 2 && (p / 2) != last_step) begin
          iter++;
          if (iter == MAX_ITER) begin
            exp_q.push_back(res_tok(0, 1, 0, 1, 1, iter));
            fin = 1'b1;
          end
        end
      end
      p++;
    end
  endtask

  // ---------------- monitor ----------------
  initial begin : monitor
    int         len_c[3];
    int         done_c;
    int         tail_c;
    logic [2:0] p_en;
    logic [2:0] en;
    logic       p_busy;
    p_en = '0; p_busy = 1'b0; done_c = 0; tail_c = 0;
    for (int i = 0; i < 3; i++) len_c[i] = 0;
    forever begin
      @(negedge CLK);
      en = {Change_State, Step_Enable, Euler_Enable};
      if (!mon_en) begin
        for (int i = 0; i < 3; i++) len_c[i] = 0;
        done_c = 0;
        tail_c = 0;
      end else begin
        if (Busy && !p_busy) begin
          done_c = 0;
          tail_c = 0;
        end
        if (Busy && en == 3'b000 && tail_c < 3) tail_c++;
        if (Done_Processing && done_c < 3) done_c++;
        for (int i = 0; i < 3; i++) begin
          if (en[i]) len_c[i]++;
          if (!en[i] && p_en[i]) begin
            sb_check("phase_len", ph_tok(i + 1, len_c[i]));
            len_c[i] = 0;
          end
        end
        if (!Busy && p_busy)
          sb_check("run_result", res_tok(done_c, Abort_Flag, Timeout_Flag, Overflow_Flag,
                                         tail_c, int'(Iter_Count)));
      end
      p_en   = en;
      p_busy = Busy;
    end
  end

  // ---------------- driver ----------------
  task automatic clear_inputs();
    Process = 0; INT = 0; Euler_End = 0; Step_End = 0; Step_Last = 0; Change_State_End = 0;
  endtask

  task automatic run_scenario();
    int         pi;
    int         cnt;
    int         budget;
    int         t;
    bit         fin;
    bit         first;
    logic [2:0] en;
    logic [2:0] prev_en;
    pi = -1; cnt = 0; budget = 0; fin = 1'b0; first = 1'b1; prev_en = '0;
    @(negedge CLK);
    Process = 1'b1;
    while (!fin && budget < 300) begin
      @(negedge CLK);
      budget++;
      Euler_End = 0; Step_End = 0; Change_State_End = 0; INT = 0;
      Step_Last = 1'($urandom_range(0, 1));
      Process   = Busy ? 1'($urandom_range(0, 1)) : 1'b0;
      if (first) begin
        chk("start_euler_en", 32'(Euler_Enable), 1);
        chk("start_busy", 32'(Busy), 1);
        chk("start_flags", {29'd0, Abort_Flag, Timeout_Flag, Overflow_Flag}, 0);
        chk("start_iter", 32'(Iter_Count), 0);
        first = 1'b0;
      end
      en = {Change_State, Step_Enable, Euler_Enable};
      if (en != 3'b000) begin
        if (en != prev_en) begin pi++; cnt = 1; end
        else cnt++;
      end
      prev_en = en;
      if (en != 3'b000) begin
        t = en[2] ? 3 : (en[1] ? 2 : 1);
        if (t != 1) Euler_End        = 1'($urandom_range(0, 1));
        if (t != 2) Step_End         = 1'($urandom_range(0, 1));
        if (t != 3) Change_State_End = 1'($urandom_range(0, 1));
        if (rst_mode && t == 3) begin
          #2 RST = 1'b1;
          #1;
          chk("rst_async_cs", 32'(Change_State), 0);
          chk("rst_async_busy", 32'(Busy), 0);
          chk("rst_async_done", 32'(Done_Processing), 0);
          clear_inputs();
          @(negedge CLK);
          RST = 1'b0;
          repeat (3) begin
            @(negedge CLK);
            chk("post_rst_done", 32'(Done_Processing), 0);
            chk("post_rst_busy", 32'(Busy), 0);
          end
          fin = 1'b1;
        end else if (pi >= 0 && pi < 16) begin
          if (pi == int_ph && cnt == int_c) INT = 1'b1;
          if (pi != hang_ph && cnt == lat[pi]) begin
            case (t)
              1: Euler_End = 1'b1;
              2: begin Step_End = 1'b1; Step_Last = ((pi / 2) == last_step); end
              default: Change_State_End = 1'b1;
            endcase
          end
        end
      end
      if (!Busy) fin = 1'b1;
    end
    if (!fin) begin
      errors++;
      $display("FAIL run_budget: run still busy after %0d cycles, required to finish", budget);
    end
    clear_inputs();
  endtask

  task automatic set_defaults();
    for (int i = 0; i < 16; i++) lat[i] = 2;
    last_step = 2; hang_ph = -1; int_ph = -1; int_c = 1; rst_mode = 1'b0;
  endtask

  task automatic do_run();
    model_push();
    run_scenario();
    repeat ($urandom_range(0, 3)) @(negedge CLK);
  endtask

  // ---------------- main ----------------
  initial begin
    clear_inputs();
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    chk("rst_enables", {29'd0, Euler_Enable, Step_Enable, Change_State}, 0);
    chk("rst_done_busy", {30'd0, Done_Processing, Busy}, 0);
    chk("rst_flags", {29'd0, Abort_Flag, Timeout_Flag, Overflow_Flag}, 0);
    chk("rst_iter", 32'(Iter_Count), 0);
    RST = 1'b0;

    // Ends and INT while idle must not start anything.
    Euler_End = 1; Step_End = 1; Step_Last = 1; Change_State_End = 1; INT = 1;
    repeat (3) @(negedge CLK);
    chk("idle_spurious_busy", 32'(Busy), 0);
    chk("idle_spurious_en", {29'd0, Euler_Enable, Step_Enable, Change_State}, 0);
    clear_inputs();
    @(negedge CLK);

    // normal run: Step_Last on the third Step_End
    set_defaults();
    do_run();
    // overflow
    set_defaults(); last_step = 99;
    do_run();
    // Euler timeout
    set_defaults(); hang_ph = 0;
    do_run();
    // INT together with the final Step_End
    set_defaults(); last_step = 0; int_ph = 1; int_c = 2;
    do_run();
    // reset in the middle of interpolation, then a fresh run
    set_defaults(); last_step = 0; rst_mode = 1'b1;
    repeat (2) @(negedge CLK);
    mon_en = 1'b0;
    run_scenario();
    mon_en = 1'b1;
    set_defaults(); last_step = 1;
    do_run();
    // minimum-latency run
    set_defaults(); last_step = 0;
    for (int i = 0; i < 16; i++) lat[i] = 1;
    do_run();

    for (int r = 0; r < 30; r++) begin
      set_defaults();
      for (int i = 0; i < 16; i++) lat[i] = $urandom_range(1, 4);
      last_step = $urandom_range(0, 4);
      if (last_step == 4) last_step = 99;
      if ($urandom_range(0, 3) == 0) hang_ph = $urandom_range(0, 8);
      if ($urandom_range(0, 3) == 0) begin
        int_ph = $urandom_range(0, 8);
        int_c  = $urandom_range(1, (int_ph == hang_ph) ? TO_CYC : lat[int_ph]);
      end
      do_run();
    end

    repeat (4) @(negedge CLK);
    chk("sb_queue_empty", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/solver_sequencer.md
# solver_sequencer

Top-level phase sequencer for one ODE solve run. On a Process request it alternates the Euler and Step phases until the Step module reports the final time point, then hands over to the interpolator and signals Done_Processing to I/O. Sits in the coordinator, driving the Euler_Enable, Step_Enable and Change_State controls. It supervises each phase with a watchdog, an iteration limit and an external INT abort.

## Interface
- ITER_WIDTH, 16, width of the iteration counter.
- MAX_ITER, 1000, maximum Euler+Step iterations before an overflow abort.
- TIMEOUT_WIDTH, 13, width of the per-phase watchdog counter.
- TIMEOUT_CYCLES, 4096, maximum number of cycles a phase may wait for its End.

Ports:
- CLK  in  1  system clock; single clock domain.
- RST  in  1  asynchronous, active-high reset.
- Process  in  1  start request from I/O, level-sampled in IDLE.
- INT  in  1  abort request, level-sampled.
- Euler_End  in  1  Euler phase complete, one-cycle pulse or level.
- Step_End  in  1  Step phase complete.
- Step_Last  in  1  qualifies Step_End: final time point reached.
- Change_State_End  in  1  interpolator complete.
- Euler_Enable  out  1  Euler phase run.
- Step_Enable  out  1  Step phase run.
- Change_State  out  1  interpolator run.
- Done_Processing  out  1  one-cycle pulse on normal completion.
- Busy  out  1  high in every state except IDLE.
- Abort_Flag, Timeout_Flag, Overflow_Flag  out  1 each  sticky error flags.
- Iter_Count  out  ITER_WIDTH  completed Euler+Step iterations.

## Operation
- States:
  - IDLE
  - EULER_RUN
  - STEP_RUN
  - INTERP
  - DONE
  - ABORT
- All outputs are registered. Reset value of every output is 0; state is IDLE.
- IDLE:
  - Process=1 → EULER_RUN.
  - Clears Iter_Count, all three flags and the watchdog.
- EULER_RUN:
  - Euler_Enable=1.
  - Euler_End=1 → STEP_RUN.
- STEP_RUN:
  - Step_Enable=1.
  - Step_End=1 with Step_Last=1 → INTERP.
  - Step_End=1 with Step_Last=0 → Iter_Count+1.
    - If the new count equals MAX_ITER → ABORT with Overflow_Flag set.
    - Otherwise → EULER_RUN.
- INTERP:
  - Change_State=1.
  - Change_State_End=1 → DONE.
- DONE: Done_Processing=1 for one cycle → IDLE.
- ABORT:
  - Sets Abort_Flag.
  - All enables are 0.
  - Holds one cycle → IDLE. Done_Processing is not asserted.
  - Flags stay set until the next accepted Process.
- Watchdog:
  - Clears on every state entry and increments each cycle in the RUN/INTERP states.
  - Reaching TIMEOUT_CYCLES-1 without the matching End → ABORT with Timeout_Flag set.
- Priority within one cycle: INT > matching End > watchdog/overflow.
  - INT in IDLE, DONE or ABORT is ignored.
- An End input is ignored outside its own state.
- Process while Busy is ignored.
- Iter_Count saturates; it never wraps, because overflow aborts first.

## Timing
- Process sampled at edge k → Euler_Enable=1 from k+1.
- An End sampled at edge k:
  - The current enable is 0 from k+1.
  - The next enable is 1 from k+1 (back-to-back, no bubble).
- One Euler+Step iteration costs at least 2 cycles.
- Minimum run (1 iteration, zero-latency Ends):
  - Process at edge 0, Done_Processing high in cycle 4.
  - Busy low from cycle 5.
- INT sampled at edge k → ABORT at k+1, with all enables 0. IDLE at k+2.
- Asynchronous RST mid-run:
  - Forces IDLE and all outputs to 0 immediately.
  - No Done_Processing is generated.

## Test plan
- Bench parameters: MAX_ITER=4, TIMEOUT_CYCLES=8.
- Normal run: Process pulse; Ends returned 2 cycles after each enable; Step_Last on the 3rd Step_End.
  - Enables alternate E,S,E,S,E,S.
  - Iter_Count=2.
  - Change_State is 1 until End.
  - One Done_Processing pulse; flags 0.
- Overflow: Step_Last held 0.
  - After the 4th Step_End: Overflow_Flag=1, Abort_Flag=1, Iter_Count=4.
  - No Done_Processing; IDLE two cycles later.
- Timeout: Euler_End never asserted.
  - Euler_Enable drops after 8 cycles.
  - Timeout_Flag=1, Abort_Flag=1.
- INT in the same cycle as Step_End (Step_Last=1).
  - ABORT wins: Change_State stays 0 and Abort_Flag=1.
- Spurious inputs:
  - Euler_End in IDLE causes no state change.
  - Process during STEP_RUN is ignored.
  - A new Process after an abort clears all flags and Iter_Count.
- Reset mid-INTERP:
  - RST asserted asynchronously: Change_State, Busy and Done_Processing drop to 0 without waiting for a clock edge.
  - After release, a Process starts a fresh run.
